iiitb_elc_scan: RTL and testbench

Parametrised successor to the single-request elevator controller. It serves up to `FLOORS` floors from a latched bitmap of pending calls, using a SCAN (sweep) policy. It adds timed floor travel, a door-dwell timer, and door-hold and overweight alerts. It sits behind the user-project IO wrapper: call buttons and sensors arrive on `io_in`, and status goes out on `io_out`.

---
 rtl/iiitb_elc_scan.sv | 259 +++++++++++++++++++++++++
 tb/tb_iiitb_elc_scan.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iiitb_elc_scan.sv
// iiitb_elc_scan -- SCAN (sweep) elevator controller for up to FLOORS floors.
//
// Calls are latched into a pending bitmap. The car keeps sweeping in its current
// direction while calls remain ahead of it, then reverses. Travel between floors
// takes MOVE_CYCLES clocks. The door dwells for at least DOOR_CYCLES clocks and is
// held open by door_block or over_weight. A long hold raises door_alert.
//
// Optional feature macro: ELC_FIRE_RECALL_EN (adds the fire_recall input and
// recall-to-ground behaviour). The default build leaves it undefined.
//
// Ports:
//   clk               in   single clock
//   reset             in   synchronous, active-high
//   call_req          in   [FLOORS] per-floor call, pulse or level
//   init_floor        in   [FW] car position loaded during reset (clamped)
//   over_weight       in   load above limit (acted on only with the door open)
//   door_block        in   obstruction sensor, holds the door open
//   fire_recall       in   recall to floor 0 (only with ELC_FIRE_RECALL_EN)
//   out_current_floor out  [FW] current floor
//   pending           out  [FLOORS] latched call map
//   direction         out  1 = up, 0 = down
//   moving            out  car travelling between floors
//   door_open         out  door open
//   complete          out  idle with nothing pending
//   door_alert        out  door held open for ALERT_CYCLES or more
//   weight_alert      out  overweight while the door is open
module iiitb_elc_scan #(
  parameter int FLOORS       = 8,
  parameter int MOVE_CYCLES  = 4,
  parameter int DOOR_CYCLES  = 6,
  parameter int ALERT_CYCLES = 20,
  localparam int FW          = $clog2(FLOORS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] call_req,
  input  logic [FW-1:0]     init_floor,
  input  logic              over_weight,
  input  logic              door_block,
`ifdef ELC_FIRE_RECALL_EN
  input  logic              fire_recall,
`endif
  output logic [FW-1:0]     out_current_floor,
  output logic [FLOORS-1:0] pending,
  output logic              direction,
  output logic              moving,
  output logic              door_open,
  output logic              complete,
  output logic              door_alert,
  output logic              weight_alert
);

  localparam int MCW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int DCW = $clog2(ALERT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_DOOR = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [FW-1:0]    floor_n, nf;
  logic             dir_n;
  logic [MCW-1:0]   mv_cnt, mv_cnt_n;
  logic [DCW-1:0]   dw_cnt, dw_cnt_n, dw_inc;
  logic             alert_n;
  logic [FLOORS-1:0] served, pending_n;
  logic             recall;

  // Decision inputs for the floor the car is standing at (IDLE / DOOR).
  logic [FLOORS-1:0] here_m, above_m, below_m;
  logic             dec_door, dec_move, dec_dir;
  // Decision inputs for the floor the car steps onto (MOVE wrap).
  logic [FLOORS-1:0] nf_here_m, nf_above_m, nf_below_m;
  logic             hold;

`ifdef ELC_FIRE_RECALL_EN
  assign recall = fire_recall;
`else
  assign recall = 1'b0;
`endif

  function automatic logic [FLOORS-1:0] onehot(input logic [FW-1:0] f);
    logic [FLOORS-1:0] m;
    for (int i = 0; i < FLOORS; i++) m[i] = (i == int'(f));
    return m;
  endfunction

  function automatic logic [FLOORS-1:0] above_mask(input logic [FW-1:0] f);
    logic [FLOORS-1:0] m;
    for (int i = 0; i < FLOORS; i++) m[i] = (i > int'(f));
    return m;
  endfunction

  function automatic logic [FLOORS-1:0] below_mask(input logic [FW-1:0] f);
    logic [FLOORS-1:0] m;
    for (int i = 0; i < FLOORS; i++) m[i] = (i < int'(f));
    return m;
  endfunction

  function automatic logic [FW-1:0] clamp_floor(input logic [FW-1:0] f);
    if (int'(f) > FLOORS - 1) return FW'(FLOORS - 1);
    return f;
  endfunction

  assign here_m  = pending & onehot(out_current_floor);
  assign above_m = pending & above_mask(out_current_floor);
  assign below_m = pending & below_mask(out_current_floor);

  // Neighbouring floor in the travel direction; both ends saturate.
  always_comb begin
    nf = out_current_floor;
    if (direction) begin
      if (out_current_floor != FW'(FLOORS - 1)) nf = out_current_floor + FW'(1);
    end else begin
      if (out_current_floor != '0) nf = out_current_floor - FW'(1);
    end
  end

  assign nf_here_m  = pending & onehot(nf);
  assign nf_above_m = pending & above_mask(nf);
  assign nf_below_m = pending & below_mask(nf);

  // IDLE decision rule. Under recall the only target is floor 0.
  always_comb begin
    dec_door = 1'b0;
    dec_move = 1'b0;
    dec_dir  = direction;
    if (recall) begin
      dec_door = (out_current_floor == '0);
      dec_move = (out_current_floor != '0);
      dec_dir  = 1'b0;
    end else begin
      dec_door = |here_m;
      dec_move = |above_m || |below_m;
      // With calls on both sides keep sweeping the same way.
      if (|above_m && |below_m) dec_dir = direction;
      else                      dec_dir = |above_m;
    end
  end

  assign dw_inc = (dw_cnt == DCW'(ALERT_CYCLES - 1)) ? dw_cnt : dw_cnt + DCW'(1);

  always_comb begin
    state_n  = state;
    floor_n  = out_current_floor;
    dir_n    = direction;
    mv_cnt_n = mv_cnt;
    dw_cnt_n = dw_cnt;
    alert_n  = door_alert;
    served   = '0;
    hold     = 1'b0;

    case (state)
      S_IDLE: begin
        if (dec_door) begin
          state_n  = S_DOOR;
          dw_cnt_n = '0;
          alert_n  = 1'b0;
          served   = onehot(out_current_floor);
        end else if (dec_move) begin
          state_n  = S_MOVE;
          mv_cnt_n = '0;
          dir_n    = dec_dir;
        end
      end

      S_MOVE: begin
        if (recall && direction) begin
          // Recall while heading up: turn round on the spot, restart the leg.
          dir_n    = 1'b0;
          mv_cnt_n = '0;
        end else if (mv_cnt == MCW'(MOVE_CYCLES - 1)) begin
          mv_cnt_n = '0;
          floor_n  = nf;
          if (recall) begin
            if (nf == '0) begin
              state_n  = S_DOOR;
              dw_cnt_n = '0;
              alert_n  = 1'b0;
            end
          end else if (|nf_here_m) begin
            state_n  = S_DOOR;
            dw_cnt_n = '0;
            alert_n  = 1'b0;
            served   = onehot(nf);
          end else if (direction ? |nf_above_m : |nf_below_m) begin
            state_n = S_MOVE;
          end else if (direction ? |nf_below_m : |nf_above_m) begin
            dir_n = ~direction;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          mv_cnt_n = mv_cnt + MCW'(1);
        end
      end

      S_DOOR: begin
        dw_cnt_n = dw_inc;
        alert_n  = recall ? 1'b0 : (door_alert || (dw_inc == DCW'(ALERT_CYCLES - 1)));
        hold     = over_weight || door_block ||
                   (dw_cnt < DCW'(DOOR_CYCLES - 1)) ||
                   (recall && out_current_floor == '0);
        if (!hold) begin
          // Closing: same choice as IDLE; the floor only reopens if re-called.
          alert_n = 1'b0;
          if (dec_door) begin
            state_n  = S_DOOR;
            dw_cnt_n = '0;
            served   = onehot(out_current_floor);
          end else if (dec_move) begin
            state_n  = S_MOVE;
            mv_cnt_n = '0;
            dir_n    = dec_dir;
          end else begin
            state_n = S_IDLE;
          end
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  // A clear from a door opening beats a simultaneous call on the same bit.
  assign pending_n = recall ? '0 : ((pending | call_req) & ~served);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      out_current_floor <= clamp_floor(init_floor);
      pending           <= '0;
      direction         <= 1'b1;
      moving            <= 1'b0;
      door_open         <= 1'b0;
      complete          <= 1'b1;
      door_alert        <= 1'b0;
      weight_alert      <= 1'b0;
      mv_cnt            <= '0;
      dw_cnt            <= '0;
    end else begin
      state             <= state_n;
      out_current_floor <= floor_n;
      pending           <= pending_n;
      direction         <= dir_n;
      moving            <= (state_n == S_MOVE);
      door_open         <= (state_n == S_DOOR);
      complete          <= (state_n == S_IDLE) && (pending_n == '0);
      door_alert        <= alert_n;
      weight_alert      <= over_weight && (state == S_DOOR);
      mv_cnt            <= mv_cnt_n;
      dw_cnt            <= dw_cnt_n;
    end
  end

endmodule

// File: tb/tb_iiitb_elc_scan.sv
// Directed bench for iiitb_elc_scan with default parameters (8 floors,
// 4 cycles per floor, 6-cycle dwell, alert at 20 cycles).
module tb_iiitb_elc_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] call_req;
  logic [2:0] init_floor;
  logic       over_weight;
  logic       door_block;
`ifdef ELC_FIRE_RECALL_EN
  logic       fire_recall;
`endif
  logic [2:0] out_current_floor;
  logic [7:0] pending;
  logic       direction, moving, door_open, complete, door_alert, weight_alert;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iiitb_elc_scan dut (
    .clk               (clk),
    .reset             (reset),
    .call_req          (call_req),
    .init_floor        (init_floor),
    .over_weight       (over_weight),
    .door_block        (door_block),
`ifdef ELC_FIRE_RECALL_EN
    .fire_recall       (fire_recall),
`endif
    .out_current_floor (out_current_floor),
    .pending           (pending),
    .direction         (direction),
    .moving            (moving),
    .door_open         (door_open),
    .complete          (complete),
    .door_alert        (door_alert),
    .weight_alert      (weight_alert)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [2:0] f);
    reset = 1'b1;
    init_floor = f;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  int nd, tog, n;
  logic pd, pdir;
  logic [2:0] dfl [4];

  initial begin
    reset = 1'b1; call_req = '0; init_floor = '0; over_weight = 1'b0; door_block = 1'b0;
`ifdef ELC_FIRE_RECALL_EN
    fire_recall = 1'b0;
`endif
    for (int i = 0; i < 4; i++) dfl[i] = '0;

    // Reset values
    tick(); tick();
    chk("rst_floor", 32'(out_current_floor), 32'd0);
    chk("rst_pending", 32'(pending), 32'h00);
    chk("rst_direction", 32'(direction), 32'd1);
    chk("rst_complete", 32'(complete), 32'd1);
    chk("rst_moving", 32'(moving), 32'd0);
    chk("rst_door", 32'(door_open), 32'd0);
    chk("rst_alerts", 32'({door_alert, weight_alert}), 32'd0);
    reset = 1'b0;
    tick();

    // Single call to floor 3 from floor 0
    call_req = 8'h08; tick(); call_req = '0;
    chk("t1_pending", 32'(pending), 32'h08);
    chk("t1_moving_early", 32'(moving), 32'd0);
    chk("t1_complete_busy", 32'(complete), 32'd0);
    tick();
    chk("t1_moving_rise", 32'(moving), 32'd1);
    ticks(3);
    chk("t1_floor_hold", 32'(out_current_floor), 32'd0);
    tick();
    chk("t1_floor1", 32'(out_current_floor), 32'd1);
    ticks(4);
    chk("t1_floor2", 32'(out_current_floor), 32'd2);
    ticks(4);
    chk("t1_floor3", 32'(out_current_floor), 32'd3);
    chk("t1_door_arrive", 32'(door_open), 32'd1);
    chk("t1_moving_stop", 32'(moving), 32'd0);
    chk("t1_pending_clr", 32'(pending), 32'h00);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!door_open) break;
      n++;
    end
    chk("t1_dwell_len", 32'(n), 32'd6);
    chk("t1_complete", 32'(complete), 32'd1);

    // Sweep: heading up to 5, calls at 0 and 7 arrive at floor 2
    do_reset(3'd0);
    call_req = 8'h20; tick(); call_req = '0;
    tick();
    ticks(8);
    chk("t2_floor2", 32'(out_current_floor), 32'd2);
    chk("t2_dir_up", 32'(direction), 32'd1);
    nd = 0; tog = 0; pd = door_open; pdir = direction;
    call_req = 8'h81; tick(); call_req = '0;
    for (int i = 0; i < 400; i++) begin
      if (door_open && !pd) begin
        if (nd < 4) dfl[nd] = out_current_floor;
        nd++;
      end
      if (direction != pdir) tog++;
      pd = door_open; pdir = direction;
      if (complete) break;
      tick();
    end
    chk("t2_stops", 32'(nd), 32'd3);
    chk("t2_stop0", 32'(dfl[0]), 32'd5);
    chk("t2_stop1", 32'(dfl[1]), 32'd7);
    chk("t2_stop2", 32'(dfl[2]), 32'd0);
    chk("t2_dir_toggles", 32'(tog), 32'd1);
    chk("t2_complete", 32'(complete), 32'd1);

    // Call at the current floor while idle at 5
    do_reset(3'd5);
    call_req = 8'h20; tick(); call_req = '0;
    chk("t3_pending", 32'(pending), 32'h20);
    chk("t3_door_early", 32'(door_open), 32'd0);
    tick();
    chk("t3_door", 32'(door_open), 32'd1);
    chk("t3_no_move", 32'(moving), 32'd0);
    chk("t3_floor", 32'(out_current_floor), 32'd5);
    chk("t3_pending_clr", 32'(pending), 32'h00);
    ticks(6);
    chk("t3_closed", 32'(door_open), 32'd0);

    // Door held by obstruction for 30 cycles
    door_block = 1'b1;
    call_req = 8'h20; tick(); call_req = '0;
    tick();
    chk("t4_door", 32'(door_open), 32'd1);
    ticks(18);
    chk("t4_alert_c19", 32'(door_alert), 32'd0);
    tick();
    chk("t4_alert_c20", 32'(door_alert), 32'd1);
    ticks(10);
    chk("t4_door_held", 32'(door_open), 32'd1);
    chk("t4_alert_held", 32'(door_alert), 32'd1);
    door_block = 1'b0;
    tick();
    chk("t4_closed", 32'(door_open), 32'd0);
    chk("t4_alert_clr", 32'(door_alert), 32'd0);

    // Overweight during travel, then during the dwell
    call_req = 8'h80; tick(); call_req = '0;
    tick();
    over_weight = 1'b1;
    ticks(4);
    chk("t5_floor6", 32'(out_current_floor), 32'd6);
    chk("t5_moving", 32'(moving), 32'd1);
    chk("t5_walert_move", 32'(weight_alert), 32'd0);
    ticks(3);
    over_weight = 1'b0;
    tick();
    chk("t5_floor7", 32'(out_current_floor), 32'd7);
    chk("t5_door", 32'(door_open), 32'd1);
    ticks(2);
    over_weight = 1'b1;
    tick();
    chk("t5_walert_on", 32'(weight_alert), 32'd1);
    ticks(9);
    chk("t5_door_held", 32'(door_open), 32'd1);
    chk("t5_walert_held", 32'(weight_alert), 32'd1);
    over_weight = 1'b0;
    tick();
    chk("t5_closed", 32'(door_open), 32'd0);
    chk("t5_walert_off", 32'(weight_alert), 32'd0);

    // Reset in the middle of a downward trip
    call_req = 8'h01; tick(); call_req = '0;
    tick();
    ticks(8);
    chk("t6_floor5", 32'(out_current_floor), 32'd5);
    chk("t6_dir_down", 32'(direction), 32'd0);
    tick();
    init_floor = 3'd6;
    reset = 1'b1;
    tick();
    chk("t6_floor_reload", 32'(out_current_floor), 32'd6);
    chk("t6_pending", 32'(pending), 32'h00);
    chk("t6_moving", 32'(moving), 32'd0);
    chk("t6_complete", 32'(complete), 32'd1);
    chk("t6_direction", 32'(direction), 32'd1);
    reset = 1'b0;
    tick();
    chk("t6_idle_floor", 32'(out_current_floor), 32'd6);
    chk("t6_idle_still", 32'({moving, door_open}), 32'd0);

`ifdef ELC_FIRE_RECALL_EN
    // Recall while travelling up past floor 4
    do_reset(3'd2);
    call_req = 8'h80; tick(); call_req = '0;
    tick();
    ticks(8);
    chk("fr_floor4", 32'(out_current_floor), 32'd4);
    tick();
    fire_recall = 1'b1;
    tick();
    chk("fr_reverse", 32'(direction), 32'd0);
    chk("fr_pending", 32'(pending), 32'h00);
    ticks(15);
    chk("fr_floor1", 32'(out_current_floor), 32'd1);
    chk("fr_moving", 32'(moving), 32'd1);
    tick();
    chk("fr_floor0", 32'(out_current_floor), 32'd0);
    chk("fr_door", 32'(door_open), 32'd1);
    ticks(30);
    chk("fr_door_held", 32'(door_open), 32'd1);
    chk("fr_alert_sup", 32'(door_alert), 32'd0);
    fire_recall = 1'b0;
    tick();
    chk("fr_closed", 32'(door_open), 32'd0);
    tick();
    chk("fr_complete", 32'(complete), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
